qpp_interleaver_pingpong: RTL and testbench
===========================================

// Module: qpp_interleaver_pingpong
// PURPOSE
// - Turbo-coder input stage: collects IN_W-bit words of a code block into a ping-pong buffer, then streams
//   c(i) and c(pi(i)) one bit pair per cycle to the two constituent encoders.
// - Computes pi(i) = (F1*i + F2*i^2) mod K on the fly, using no remap network. Supports two runtime-selectable
//   block sizes; the next block loads while the current block drains.
// PARAMETERS
// - K_SMALL   1056 : block size when k_large=0 (bits)
// - F1_SMALL  17   : QPP f1 for K_SMALL
// - F2_SMALL  66   : QPP f2 for K_SMALL
// - K_LARGE   6144 : block size when k_large=1; also the depth of each bank (bits)
// - F1_LARGE  263  : QPP f1 for K_LARGE
// - F2_LARGE  480  : QPP f2 for K_LARGE
// - IN_W      8    : input word width; must divide K_SMALL and K_LARGE
// PORTS
// - clock        in   1      single clock, rising edge
// - rst          in   1      asynchronous, active-low reset
// - in_valid     in   1      in_data/in_k_large valid
// - in_ready     out  1      buffer can accept a word
// - in_data      in   IN_W   block data; bit 0 = earliest bit c(n)
// - in_k_large   in   1      block size select, sampled on the first word of each block
// - out_valid    out  1      out_ci/out_cpi valid
// - out_ready    in   1      downstream accepts the current bit pair
// - out_ci       out  1      c(i), natural order
// - out_cpi      out  1      c(pi(i)), interleaved order
// - out_first    out  1      asserted with i==0
// - out_last     out  1      asserted with i==K-1
// - out_k_large  out  1      size of the block being drained
// BEHAVIOUR
// - Reset (rst=0, async): both banks empty, wr_bank=rd_bank=0, word/bit counters 0, FSM IDLE.
//   All outputs 0 except in_ready=1. Bank contents are not cleared.
// - Write side: a word transfers on in_valid&in_ready and is written to bits [w*IN_W +: IN_W] of bank wr_bank.
//   - The first word of a block latches k_large for that bank.
//   - After word K/IN_W-1 (132 or 768 words at defaults), that bank's full flag is set, wr_bank toggles, word count clears.
//   - in_ready = !full[wr_bank] (registered state only, no combinational path from out_ready).
// - Read FSM: IDLE -> RUN when full[rd_bank]; i=0, pi=0, g=(F1+F2) mod K; out_valid rises the cycle after the flag sets.
//   - RUN: the bit pair transfers on out_valid&out_ready. Then i++, pi=(pi+g) mod K, g=(g+2*F2) mod K.
//     Each mod is a single conditional subtract of K; operands are < K, IDX_W=clog2(K_LARGE)+1 bits.
//   - out_ci=bank[rd_bank][i] and out_cpi=bank[rd_bank][pi]; both are held stable while out_valid&!out_ready.
//   - Transfer of i==K-1 clears full[rd_bank] and toggles rd_bank.
//     If the other bank is full, RUN restarts at i=0 in the next cycle with no bubble; otherwise -> IDLE.
// - Simultaneous events:
//   - The last write of bank A and the last read of bank B in the same cycle both take effect.
//   - If a bank completes filling in the cycle the reader looks at it, the reader sees it one cycle later (no bypass).
//   - Both banks full: in_ready=0 until the drain of rd_bank completes; in_ready rises in the following cycle.
// - Mid-operation reset discards partial and complete blocks; outputs return to reset values immediately.
// - The block size of a bank is fixed once its first word is accepted; in_k_large on later words is ignored.
// TESTING
// - Load K=1056, word0=0x01, rest 0x00 -> first transfer out_first=1, out_ci=1, out_cpi=1; all other out_ci=0;
//   out_cpi=1 only where pi(i)=0.
// - Load K=1056 with c(n)=parity(n), ready held high -> the out_cpi sequence matches the reference model.
//   pi(1)=83, pi(2)=298; out_last at transfer 1056.
// - Load K=6144 with random data -> pi(1)=743, pi(2)=2446, pi(6143) per the reference model.
//   Exactly 6144 transfers; out_k_large=1 throughout.
// - Back-to-back: three blocks (1056, 6144, 1056) with in_valid stuck high.
//   -> 1056+6144+1056 contiguous transfers with no out_valid gap; in_ready=0 while both banks are full.
// - Backpressure: toggle out_ready randomly at 50% -> outputs stable while stalled; sequence identical to the no-stall run.
// - Async reset asserted after 50 words of a block, then released -> in_ready=1, out_valid=0.
//   A fresh 1056 block then drains correctly.

Source files
------------

// File: rtl/qpp_interleaver_pingpong.sv
// Turbo input stage: ping-pong bit buffer filled IN_W bits at a time, drained as c(i) / c(pi(i)) pairs
// with the QPP index pi(i) stepped incrementally. IN_W must be a power of two dividing both block sizes.
module qpp_interleaver_pingpong #(
   parameter int K_SMALL  = 1056,
   parameter int F1_SMALL = 17,
   parameter int F2_SMALL = 66,
   parameter int K_LARGE  = 6144,
   parameter int F1_LARGE = 263,
   parameter int F2_LARGE = 480,
   parameter int IN_W     = 8
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_k_large,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_ci,
   output logic            out_cpi,
   output logic            out_first,
   output logic            out_last,
   output logic            out_k_large
);
   localparam int IDX_W = $clog2(K_LARGE) + 1;
   localparam int WORDS = K_LARGE / IN_W;
   localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OFF_W = (IN_W > 1) ? $clog2(IN_W) : 1;

   localparam logic [WC_W-1:0]  WL_S = WC_W'(K_SMALL / IN_W - 1);
   localparam logic [WC_W-1:0]  WL_L = WC_W'(K_LARGE / IN_W - 1);
   localparam logic [IDX_W-1:0] G0_S = IDX_W'((F1_SMALL + F2_SMALL) % K_SMALL);
   localparam logic [IDX_W-1:0] G0_L = IDX_W'((F1_LARGE + F2_LARGE) % K_LARGE);
   localparam logic [IDX_W-1:0] D_S  = IDX_W'((2 * F2_SMALL) % K_SMALL);
   localparam logic [IDX_W-1:0] D_L  = IDX_W'((2 * F2_LARGE) % K_LARGE);

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [IDX_W-1:0] k_of(input logic kl);
      return kl ? IDX_W'(K_LARGE) : IDX_W'(K_SMALL);
   endfunction

   // Operands are both < k, so one conditional subtract completes the reduction.
   function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b,
                                                input logic [IDX_W-1:0] k);
      logic [IDX_W-1:0] s;
      s = a + b;
      return (s >= k) ? s - k : s;
   endfunction

   logic [IN_W-1:0]  mem [2][WORDS];
   logic [1:0]       full;
   logic [1:0]       kl_bank;
   logic             wr_bank, rd_bank;
   logic [WC_W-1:0]  wcnt;
   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx_i, idx_pi, gap_g;
   logic [IDX_W-1:0] idx_i_nxt, idx_pi_nxt, gap_g_nxt;
   logic             wr_fire, wr_kl, wr_last;
   logic             run, rd_fire, rd_kl, rd_last;
   logic [IN_W-1:0]  w_ci, w_cpi;

   // ---------------- write side ----------------
   assign in_ready = !full[wr_bank];
   assign wr_fire  = in_valid && in_ready;
   assign wr_kl    = (wcnt == '0) ? in_k_large : kl_bank[wr_bank];
   assign wr_last  = wr_fire && (wcnt == (wr_kl ? WL_L : WL_S));

   always_ff @(posedge clock) begin
      if (wr_fire) mem[wr_bank][wcnt] <= in_data;
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wcnt    <= '0;
         wr_bank <= 1'b0;
         kl_bank <= '0;
      end else if (wr_fire) begin
         if (wcnt == '0) kl_bank[wr_bank] <= in_k_large;
         if (wr_last) begin
            wcnt    <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wcnt <= wcnt + 1'b1;
         end
      end
   end

   // Writer only touches an empty bank and the reader only a full one, so both updates never collide.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         full    <= '0;
         rd_bank <= 1'b0;
      end else begin
         if (rd_last) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
         if (wr_last) full[wr_bank] <= 1'b1;
      end
   end

   // ---------------- read FSM ----------------
   assign run     = (state == RUN);
   assign rd_kl   = kl_bank[rd_bank];
   assign rd_fire = run && out_ready;
   assign rd_last = rd_fire && (idx_i == k_of(rd_kl) - 1'b1);

   always_comb begin
      state_nxt  = state;
      idx_i_nxt  = idx_i;
      idx_pi_nxt = idx_pi;
      gap_g_nxt  = gap_g;
      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_nxt  = RUN;
               idx_i_nxt  = '0;
               idx_pi_nxt = '0;
               gap_g_nxt  = rd_kl ? G0_L : G0_S;
            end
         end
         RUN: begin
            if (rd_last) begin
               idx_i_nxt  = '0;
               idx_pi_nxt = '0;
               if (full[~rd_bank]) gap_g_nxt = kl_bank[~rd_bank] ? G0_L : G0_S;
               else                state_nxt = IDLE;
            end else if (rd_fire) begin
               idx_i_nxt  = idx_i + 1'b1;
               idx_pi_nxt = mod_add(idx_pi, gap_g, k_of(rd_kl));
               gap_g_nxt  = mod_add(gap_g, rd_kl ? D_L : D_S, k_of(rd_kl));
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         idx_i  <= '0;
         idx_pi <= '0;
         gap_g  <= '0;
      end else begin
         state  <= state_nxt;
         idx_i  <= idx_i_nxt;
         idx_pi <= idx_pi_nxt;
         gap_g  <= gap_g_nxt;
      end
   end

   // Indices are < K_LARGE, so the word select fits in WC_W bits.
   assign w_ci  = mem[rd_bank][idx_i[OFF_W +: WC_W]];
   assign w_cpi = mem[rd_bank][idx_pi[OFF_W +: WC_W]];

   assign out_valid   = run;
   assign out_ci      = run && w_ci[idx_i[OFF_W-1:0]];
   assign out_cpi     = run && w_cpi[idx_pi[OFF_W-1:0]];
   assign out_first   = run && (idx_i == '0);
   assign out_last    = run && (idx_i == k_of(rd_kl) - 1'b1);
   assign out_k_large = run && rd_kl;

endmodule

// File: tb/tb_qpp_interleaver_pingpong.sv
// Bench for qpp_interleaver_pingpong: per-block bit arrays plus a direct pi(i) formula form the model;
// one process checks every output cycle against it.
module tb_qpp_interleaver_pingpong;
   logic       clock = 1'b0, rst = 1'b0;
   logic       in_valid = 1'b0, in_k_large = 1'b0, out_ready;
   logic [7:0] in_data = '0;
   logic       in_ready, out_valid, out_ci, out_cpi, out_first, out_last, out_k_large;

   qpp_interleaver_pingpong dut (
      .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_k_large(in_k_large), .out_valid(out_valid), .out_ready(out_ready), .out_ci(out_ci),
      .out_cpi(out_cpi), .out_first(out_first), .out_last(out_last), .out_k_large(out_k_large));

   always #5 clock = ~clock;

   bit blk_bits [0:9][0:6143];
   bit blk_kl   [0:9];
   int nblk = 0, cur_blk = 0, idx = 0, xfers = 0;
   int n_assert = 0, n_fail = 0;
   int ones_ci = 0, ones_cpi = 0, gap_cnt = 0;
   bit bp_en = 0, gap_en = 0, gap_started = 0, saw_stall = 0;

   function automatic int pi_f(input int i, input bit kl);
      longint k, f1, f2;
      k  = kl ? 6144 : 1056;
      f1 = kl ? 263 : 17;
      f2 = kl ? 480 : 66;
      return int'((f1 * i + f2 * longint'(i) * i) % k);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (blk %0d idx %0d)", name, act, exp, cur_blk, idx);
      end
   endtask

   task automatic fill(input int b, input bit kl, input int pat);
      blk_kl[b] = kl;
      for (int n = 0; n < (kl ? 6144 : 1056); n++)
         case (pat)
            0:       blk_bits[b][n] = (n == 0);
            1:       blk_bits[b][n] = 1'($countones(n) & 1);
            default: blk_bits[b][n] = 1'($urandom_range(0, 1));
         endcase
   endtask

   // Sends block slot nblk; size select is inverted on later words to show it is ignored.
   task automatic send_block(input int max_words, input bit keep_valid);
      int nw, w;
      bit fire;
      nw = (blk_kl[nblk] ? 6144 : 1056) / 8;
      w  = 0;
      while (w < nw && w < max_words) begin
         @(negedge clock);
         in_valid   = 1'b1;
         in_k_large = (w == 0) ? blk_kl[nblk] : ~blk_kl[nblk];
         for (int j = 0; j < 8; j++) in_data[j] = blk_bits[nblk][w*8 + j];
         fire = in_ready;
         @(posedge clock);
         if (fire) w++;
      end
      if (w == nw) nblk++;
      if (!keep_valid) begin
         @(negedge clock);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input int budget);
      int c = 0;
      while (cur_blk < nblk && c < budget) begin
         @(posedge clock);
         c++;
      end
      check("drain_timeout", cur_blk, nblk);
   endtask

   // Compare process: owns out_ready, checks every cycle, advances the model on transfers.
   initial begin
      bit fire, kl, prev_stall, s_ci, s_cpi;
      logic [5:0] prev_vec;
      int k;
      prev_stall = 0;
      prev_vec   = '0;
      out_ready  = 1'b1;
      forever begin
         @(negedge clock);
         out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
         fire = 0;
         k    = 1056;
         if (rst) begin
            check("in_ready", in_ready, (nblk - cur_blk >= 2) ? 0 : 1);
            if (nblk - cur_blk >= 2) saw_stall = 1;
            if (prev_stall)
               check("stall_hold", {out_valid, out_ci, out_cpi, out_first, out_last, out_k_large}, prev_vec);
            if (out_valid && cur_blk >= nblk) check("spurious_valid", out_valid, 0);
            else if (out_valid) begin
               kl = blk_kl[cur_blk];
               k  = kl ? 6144 : 1056;
               check("out_ci", out_ci, blk_bits[cur_blk][idx]);
               check("out_cpi", out_cpi, blk_bits[cur_blk][pi_f(idx, kl)]);
               check("out_first", out_first, idx == 0);
               check("out_last", out_last, idx == k - 1);
               check("out_k_large", out_k_large, kl);
               fire = out_ready;
            end
            if (gap_en) begin
               if (out_valid) gap_started = 1;
               if (gap_started && gap_cnt < 8256) check("no_gap", out_valid, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = {out_valid, out_ci, out_cpi, out_first, out_last, out_k_large};
         end else prev_stall = 0;
         s_ci  = out_ci;
         s_cpi = out_cpi;
         @(posedge clock);
         if (fire) begin
            xfers++;
            ones_ci  += int'(s_ci);
            ones_cpi += int'(s_cpi);
            if (gap_en) gap_cnt++;
            idx++;
            if (idx == k) begin
               idx = 0;
               cur_blk++;
            end
         end
      end
   end

   initial begin
      repeat (90000) @(posedge clock);
      $display("FAIL watchdog: cycle budget of 90000 exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {out_ci, out_cpi, out_first, out_last, out_k_large}, 0);
      rst = 1'b1;

      check("pi_s1", pi_f(1, 0), 83);
      check("pi_s2", pi_f(2, 0), 298);
      check("pi_s1055", pi_f(1055, 0), 49);
      check("pi_l1", pi_f(1, 1), 743);
      check("pi_l2", pi_f(2, 1), 2446);
      check("pi_l6143", pi_f(6143, 1), 217);

      // single '1' at c(0)
      fill(nblk, 0, 0);
      send_block(1 << 20, 0);
      wait_drain(3000);
      check("t1_ones_ci", ones_ci, 1);
      check("t1_ones_cpi", ones_cpi, 1);
      check("t1_xfers", xfers, 1056);

      // parity pattern, small block
      fill(nblk, 0, 1);
      send_block(1 << 20, 0);
      wait_drain(3000);
      check("t2_xfers", xfers, 2112);

      // random large block
      fill(nblk, 1, 2);
      send_block(1 << 20, 0);
      wait_drain(9000);
      check("t3_xfers", xfers, 2112 + 6144);

      // back-to-back three blocks, in_valid held high
      fill(nblk, 0, 1);
      fill(nblk + 1, 1, 2);
      fill(nblk + 2, 0, 2);
      gap_en = 1;
      send_block(1 << 20, 1);
      send_block(1 << 20, 1);
      send_block(1 << 20, 0);
      wait_drain(12000);
      check("t4_contig", gap_cnt, 8256);
      check("t4_both_full_seen", saw_stall, 1);
      gap_en = 0;

      // random backpressure, parity data
      fill(nblk, 0, 1);
      bp_en = 1;
      send_block(1 << 20, 0);
      wait_drain(8000);
      bp_en = 0;
      check("t5_xfers", xfers, 2112 + 6144 + 8256 + 1056);

      // reset after 50 words, then a fresh block
      fill(nblk, 0, 2);
      send_block(50, 0);
      @(posedge clock);
      #2 rst = 1'b0;
      #1;
      check("t6_in_ready", in_ready, 1);
      check("t6_out_valid", out_valid, 0);
      repeat (3) @(negedge clock);
      rst = 1'b1;
      fill(nblk, 0, 2);
      send_block(1 << 20, 0);
      wait_drain(3000);
      check("t6_xfers", xfers, 2112 + 6144 + 8256 + 1056 + 1056);

      repeat (5) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
